// File: rtl/square_plotter.sv
// square_plotter
//
// Datapath end of the square-drawing handshake. It holds a loaded square
// origin and colour, and on request streams pixel coordinates with a plot
// strobe to the VGA adapter. It either draws a SIZE x SIZE square at the
// loaded origin, clipping pixels that fall off screen, or clears the whole
// screen to colour 0. busy/done report progress to the controlling FSM.
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   reset       synchronous, active-low reset
//   ld_en       capture x_in/y_in/colour_in (IDLE only, lowest priority)
//   x_in, y_in  square origin
//   colour_in   square colour
//   draw_go     start a square draw (IDLE only)
//   clear_go    start a full-screen clear (IDLE only, highest priority)
//   busy        high in every state except IDLE
//   x_out/y_out registered pixel coordinate
//   colour_out  registered pixel colour
//   plot        registered write strobe to the VGA adapter
//   done        one-cycle completion pulse
module square_plotter #(
  parameter int SIZE     = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ld_en,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [C_W-1:0] colour_in,
  input  logic           draw_go,
  input  logic           clear_go,
  output logic           busy,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out,
  output logic           plot,
  output logic           done
);

  localparam int OFF_HALF = $clog2(SIZE);
  localparam int OFF_W    = 2 * OFF_HALF;

  localparam logic [X_W:0]   X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] base_x_q, base_x_d;
  logic [Y_W-1:0] base_y_q, base_y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0] clr_x_q, clr_x_d;
  logic [Y_W-1:0] clr_y_q, clr_y_d;
  logic           last_q, last_d;
  logic [X_W-1:0] x_out_q, x_out_d;
  logic [Y_W-1:0] y_out_q, y_out_d;
  logic [C_W-1:0] colour_out_q, colour_out_d;
  logic           plot_q, plot_d;

  logic [OFF_W-1:0] off;
  logic [X_W:0]     x_sum;
  logic [Y_W:0]     y_sum;
  logic             pix_vis;

  // Square pixel address. The offset is forced to 0 on the accepting edge
  // so the first pixel is already registered in the first DRAW cycle.
  // Sums are one bit wider so off-screen pixels are detected before the
  // truncation to port width.
  always_comb begin
    off     = (state_q == DRAW) ? cnt_q : '0;
    x_sum   = {1'b0, base_x_q} + (X_W+1)'(off[OFF_HALF-1:0]);
    y_sum   = {1'b0, base_y_q} + (Y_W+1)'(off[OFF_W-1:OFF_HALF]);
    pix_vis = (x_sum < X_LIM) && (y_sum < Y_LIM);
  end

  // Next-state and output logic. last_q flags that the pixel currently on
  // the outputs is the final one, so the following edge moves to DONE.
  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    cnt_d        = cnt_q;
    clr_x_d      = clr_x_q;
    clr_y_d      = clr_y_q;
    last_d       = last_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    plot_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_go) begin
          state_d      = CLEAR;
          x_out_d      = '0;
          y_out_d      = '0;
          colour_out_d = '0;
          plot_d       = 1'b1;
          clr_x_d      = X_W'(1);
          clr_y_d      = '0;
          last_d       = 1'b0;
        end else if (draw_go) begin
          state_d      = DRAW;
          x_out_d      = x_sum[X_W-1:0];
          y_out_d      = y_sum[Y_W-1:0];
          colour_out_d = colour_q;
          plot_d       = pix_vis;
          cnt_d        = OFF_W'(1);
          last_d       = 1'b0;
        end else if (ld_en) begin
          base_x_d = x_in;
          base_y_d = y_in;
          colour_d = colour_in;
        end
      end

      DRAW: begin
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
        end else begin
          x_out_d      = x_sum[X_W-1:0];
          y_out_d      = y_sum[Y_W-1:0];
          colour_out_d = colour_q;
          plot_d       = pix_vis;
          cnt_d        = cnt_q + OFF_W'(1);
          last_d       = (cnt_q == '1);
        end
      end

      CLEAR: begin
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
        end else begin
          x_out_d      = clr_x_q;
          y_out_d      = clr_y_q;
          colour_out_d = '0;
          plot_d       = 1'b1;
          last_d       = (clr_x_q == X_MAX) && (clr_y_q == Y_MAX);
          if (clr_x_q == X_MAX) begin
            clr_x_d = '0;
            clr_y_d = clr_y_q + Y_W'(1);
          end else begin
            clr_x_d = clr_x_q + X_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      cnt_q        <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      last_q       <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      cnt_q        <= cnt_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      last_q       <= last_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
      plot_q       <= plot_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_square_plotter.sv
// tb_square_plotter
//
// Self-checking bench for square_plotter. Expected pixels come from a
// plain-arithmetic model of the square (origin + offset, on-screen test)
// and of the clear raster (index -> column/row), plus a table of draw
// vectors with hand-computed visible-pixel counts.
module tb_square_plotter;

  localparam int SIZE = 4;
  localparam int SW   = 160;
  localparam int SH   = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ld_en = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       draw_go = 1'b0;
  logic       clear_go = 1'b0;
  logic       busy;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Behavioural copy of the loaded origin/colour
  int model_bx = 0;
  int model_by = 0;
  int model_c  = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         exp_plots;
  } vec_t;

  vec_t vecs[6];

  square_plotter dut (
    .clock      (clock),
    .reset      (reset),
    .ld_en      (ld_en),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .draw_go    (draw_go),
    .clear_go   (clear_go),
    .busy       (busy),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .done       (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of controls; the model loads only when the design is
  // idle and no start request outranks the load.
  task automatic applyStimulus(input logic ld, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] c, input logic dg, input logic cg);
    ld_en = ld; x_in = x; y_in = y; colour_in = c; draw_go = dg; clear_go = cg;
    if (ld && !dg && !cg && !busy) begin
      model_bx = x; model_by = y; model_c = c;
    end
    tick();
    ld_en = 1'b0; draw_go = 1'b0; clear_go = 1'b0;
  endtask

  function automatic logic [31:0] pix(input int xs, input int ys, input int c, input bit pl);
    return {12'b0, 1'b1, 8'(xs), 7'(ys), 3'(c), pl};
  endfunction

  function automatic logic [31:0] outs();
    return {12'b0, busy, x_out, y_out, colour_out, plot};
  endfunction

  // Called in the first pixel cycle of a draw. Optionally injects a
  // load+draw request while busy, which must have no effect.
  task automatic drawAndCheck(input string tag, input int inject_at, output int plots);
    plots = 0;
    for (int dy = 0; dy < SIZE; dy++) begin
      for (int dx = 0; dx < SIZE; dx++) begin
        int k  = dy * SIZE + dx;
        int xs = model_bx + dx;
        int ys = model_by + dy;
        bit pl = (xs < SW) && (ys < SH);
        checkOutput($sformatf("%s_px%0d", tag, k), outs(), pix(xs, ys, model_c, pl));
        if (pl) plots++;
        if (k == inject_at) begin
          ld_en = 1'b1; x_in = 8'd50; draw_go = 1'b1;
        end
        tick();
        ld_en = 1'b0; draw_go = 1'b0;
      end
    end
    checkOutput($sformatf("%s_done", tag), {29'b0, done, busy, plot}, 32'b110);
    tick();
    checkOutput($sformatf("%s_idle", tag), {29'b0, done, busy, plot}, 32'b000);
  endtask

  task automatic clearAndCheck(input string tag, input logic also_draw);
    applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, also_draw, 1'b1);
    for (int i = 0; i < SW * SH; i++) begin
      checkOutput($sformatf("%s_px%0d", tag, i), outs(), pix(i % SW, i / SW, 0, 1'b1));
      tick();
    end
    checkOutput($sformatf("%s_done", tag), {29'b0, done, busy, plot}, 32'b110);
    tick();
    checkOutput($sformatf("%s_idle", tag), {29'b0, done, busy, plot}, 32'b000);
  endtask

  initial begin
    int plots;

    vecs[0] = '{8'd10,  7'd20,  3'b100, 16};
    vecs[1] = '{8'd158, 7'd118, 3'b011, 4};
    vecs[2] = '{8'd157, 7'd0,   3'b001, 12};
    vecs[3] = '{8'd0,   7'd117, 3'b110, 12};
    vecs[4] = '{8'd255, 7'd127, 3'b111, 0};
    vecs[5] = '{8'd156, 7'd116, 3'b010, 16};

    // Reset held for two cycles with inputs toggling
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_en = ~ld_en; draw_go = ~draw_go; clear_go = ~clear_go;
      x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
      tick();
    end
    ld_en = 1'b0; draw_go = 1'b0; clear_go = 1'b0;
    checkOutput("reset_outs", {12'b0, busy, x_out, y_out, colour_out, plot, done}, 32'b0);
    reset = 1'b1;
    tick();
    checkOutput("reset_idle", {30'b0, busy, plot}, 32'b0);

    // Table-driven square draws
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
      drawAndCheck($sformatf("vec%0d", i), -1, plots);
      checkOutput($sformatf("vec%0d_plots", i), 32'(plots), 32'(vecs[i].exp_plots));
    end

    // Full clear, then a draw that must reuse the last loaded origin
    clearAndCheck("clear", 1'b0);
    applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
    drawAndCheck("after_clear", -1, plots);

    // clear_go outranks draw_go
    clearAndCheck("clear_prio", 1'b1);

    // Load 10/20, draw with a load+draw poke mid-square; nothing changes
    applyStimulus(1'b1, 8'd10, 7'd20, 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
    drawAndCheck("busy_poke", 5, plots);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("no_redraw%0d", i), {30'b0, busy, plot}, 32'b0);
      tick();
    end

    // Load and draw at the same edge: load dropped, square still at 10/20
    applyStimulus(1'b1, 8'd77, 7'd33, 3'b001, 1'b1, 1'b0);
    drawAndCheck("ld_with_go", -1, plots);

    // Reset after the fifth pixel of a draw
    applyStimulus(1'b1, 8'd30, 7'd40, 3'b101, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("pre_reset_px%0d", k), outs(),
                  pix(30 + k % SIZE, 40 + k / SIZE, 5, 1'b1));
      if (k < 4) tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_bx = 0; model_by = 0; model_c = 0;
    checkOutput("mid_reset", {12'b0, busy, x_out, y_out, colour_out, plot, done}, 32'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("mid_reset_nodone%0d", i), {29'b0, done, busy, plot}, 32'b0);
    end
    applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
    drawAndCheck("post_reset", -1, plots);

    // Randomised squares against the model
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
                    3'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
      drawAndCheck($sformatf("rand%0d", r), -1, plots);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
